cam_pixel_probe: RTL and testbench
==================================

Name: cam_pixel_probe

Overview:
- Upstream feeder for the 8-bit blue-channel PIO input port in the camera subsystem.
- Watches the camera RGB 8:8:8 pixel stream and tracks x/y position.
- On software request, captures the blue component of the pixel at a programmed coordinate and holds it stable for the Nios to read.
- Target coordinates and arm/abort strobes come from neighbouring output PIOs.

Parameters:
CW, 11, width of coordinate counters and target inputs (frames up to 2048x2048)

Ports:
clk  input  1  system clock; single clock domain
reset_n  input  1  asynchronous active-low reset
arm  input  1  one-cycle pulse; start a capture
abort  input  1  one-cycle pulse; cancel a pending capture
target_x  input  CW  column to sample; latched on accepted arm
target_y  input  CW  row to sample; latched on accepted arm
pix_valid  input  1  pixel beat qualifier
pix_sof  input  1  with pix_valid: this beat is pixel (0,0) of a frame
pix_eol  input  1  with pix_valid: this beat is the last pixel of its line
pix_data  input  24  {R[23:16], G[15:8], B[7:0]}
blue_out  output  8  captured blue value; drives PIO in_port
done  output  1  capture complete; blue_out valid
busy  output  1  capture pending

Behaviour:
- Reset (asynchronous, any time, including mid-capture):
  - state=IDLE; blue_out=0, done=0, busy=0.
  - x_cnt=0, y_cnt=0; latched targets=0.
- State machine: IDLE, WAIT_SOF, SCAN, DONE.
- IDLE/DONE + arm:
  - Latch target_x/target_y; go to WAIT_SOF.
  - Next cycle: busy=1, done=0; blue_out keeps its old value.
- arm in WAIT_SOF or SCAN: ignored; targets not relatched.
- abort in WAIT_SOF or SCAN: go to IDLE; busy=0, done=0; blue_out held.
  - abort in IDLE/DONE: no effect.
  - arm and abort in the same cycle: abort wins. In DONE this clears done and goes to IDLE.
- WAIT_SOF: waits for pix_valid & pix_sof.
  - Pixels before the first SOF are never captured.
  - That SOF beat is coordinate (0,0) and is itself eligible for capture; go to SCAN.
- Coordinate tracking, on every pix_valid beat in any state:
  - pix_sof: beat is at (0,0); next beat at (1,0), or (0,1) if pix_eol also set.
  - Else the beat is at (x_cnt,y_cnt). If pix_eol: x_cnt=0, y_cnt+1; else x_cnt+1.
  - Both counters saturate at 2^CW-1 and do not wrap.
- SCAN:
  - Hit = pix_valid beat whose coordinate equals the latched target.
  - On the clock edge after the hit beat (1-cycle latency): blue_out=pix_data[7:0] of that beat, done=1, busy=0, state=DONE.
  - A new SOF in SCAN restarts coordinates at (0,0) and scanning continues.
  - If the target lies outside the frame, the block stays in SCAN until abort.
- DONE: blue_out and done held until the next accepted arm, abort-with-arm, or reset.
- pix_valid=0 beats: counters and state unchanged; pix_sof, pix_eol and pix_data are ignored.

Optional Feature:
- Macro: CAM_PIXEL_PROBE_AVG4_EN.
- With the macro defined:
  - Capture starts at the hit beat and accumulates blue over 4 consecutive valid beats at x..x+3 on the same row (10-bit sum).
  - blue_out = sum>>2, truncated.
  - If pix_eol occurs on an earlier collected beat, the missing beats replicate the last collected blue value.
  - done rises on the edge after the 4th beat, or after the eol beat.
  - abort during accumulation returns to IDLE with blue_out unchanged.
  - A SOF during accumulation forces a finish using the replicate rule; that SOF beat is not included.
- Without the macro: single-pixel capture exactly as in Behaviour; no accumulator logic.

Test Plan:
- Reset mid-SCAN: assert reset_n=0 during a capture -> blue_out=0x00, done=0, busy=0 immediately; after release, pixels are ignored until arm.
- Basic capture:
  - Stimulus: 8x4 frame, blue=16*y+x; arm with target (3,2).
  - Required: busy=1 the cycle after arm; done=1 and blue_out=0x23 one cycle after the (3,2) beat; value held through the next frame.
- Edge coordinates:
  - Target (0,0) -> blue_out=0x00 from the SOF beat.
  - Target (7,3) -> blue_out=0x37.
  - Arm mid-frame -> capture comes from the next frame only.
- Gapped stream: pix_valid toggling 1/0 with varying gaps, target (5,1) -> blue_out=0x15; invalid beats do not advance counters.
- Out-of-range target and control races:
  - Target (9,0) -> no done across 3 frames; abort -> busy=0, done=0.
  - arm+abort in the same cycle -> stays IDLE.
  - Second arm while busy -> ignored; original target kept.
- AVG4 (macro defined):
  - Blues 0x10, 0x20, 0x30, 0x41 at x=2..5 -> blue_out=0x28.
  - Target x=6 on an 8-wide row -> (0xA0+0xB0+0xB0+0xB0)>>2 = 0xAC with blue=0xA0 at x=6 and 0xB0 at x=7 (eol).

Source files
------------

// File: rtl/cam_pixel_probe.sv
// Samples the blue component of one pixel at a programmed (x,y) in an RGB888 stream.
// Define CAM_PIXEL_PROBE_AVG4_EN to average 4 horizontally adjacent pixels instead.
module cam_pixel_probe #(
  parameter int unsigned CW = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arm,
  input  logic          abort,
  input  logic [CW-1:0] target_x,
  input  logic [CW-1:0] target_y,
  input  logic          pix_valid,
  input  logic          pix_sof,
  input  logic          pix_eol,
  input  logic [23:0]   pix_data,
  output logic [7:0]    blue_out,
  output logic          done,
  output logic          busy
);

`ifdef CAM_PIXEL_PROBE_AVG4_EN
  typedef enum logic [2:0] {IDLE, WAIT_SOF, SCAN, DONE, ACCUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT_SOF, SCAN, DONE} state_t;
`endif

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state, state_next;
  logic [CW-1:0] x_cnt, y_cnt, x_next, y_next;
  logic [CW-1:0] tx, ty, cur_x, cur_y;
  logic [7:0]    blue_reg, blue_next, blue;
  logic          latch, hit;
  logic          unused_rg;

`ifdef CAM_PIXEL_PROBE_AVG4_EN
  logic [9:0] acc, acc_next, acc_sum;
  logic [2:0] n_cnt, n_next, n_sum;
  logic [7:0] last, last_next;

  // Completes a short run by replicating the last collected value for the missing beats.
  function automatic logic [7:0] fill(input logic [9:0] s, input logic [7:0] v,
                                      input logic [2:0] k);
    logic [2:0] rem;
    logic [9:0] tot;
    rem = 3'd4 - k;
    tot = s + {2'b00, v} * {7'b0000000, rem};
    return tot[9:2];
  endfunction
`endif

  assign blue      = pix_data[7:0];
  assign unused_rg = ^pix_data[23:8];

  // A SOF beat is (0,0) regardless of where the counters were left.
  assign cur_x = pix_sof ? '0 : x_cnt;
  assign cur_y = pix_sof ? '0 : y_cnt;
  assign hit   = pix_valid && (cur_x == tx) && (cur_y == ty);

  always_comb begin
    x_next = x_cnt;
    y_next = y_cnt;
    if (pix_valid) begin
      if (pix_eol) begin
        x_next = '0;
        y_next = (cur_y == '1) ? cur_y : cur_y + ONE;
      end else begin
        x_next = (cur_x == '1) ? cur_x : cur_x + ONE;
        y_next = cur_y;
      end
    end
  end

  always_comb begin
    state_next = state;
    blue_next  = blue_reg;
    latch      = 1'b0;
`ifdef CAM_PIXEL_PROBE_AVG4_EN
    acc_next  = acc;
    n_next    = n_cnt;
    last_next = last;
    acc_sum   = acc + {2'b00, blue};
    n_sum     = n_cnt + 3'd1;
`endif
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          if (abort) begin
            state_next = IDLE;
          end else begin
            state_next = WAIT_SOF;
            latch      = 1'b1;
          end
        end
      end
      WAIT_SOF, SCAN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (hit && (state == SCAN || pix_sof)) begin
`ifdef CAM_PIXEL_PROBE_AVG4_EN
          acc_next  = {2'b00, blue};
          n_next    = 3'd1;
          last_next = blue;
          if (pix_eol) begin
            blue_next  = blue;
            state_next = DONE;
          end else begin
            state_next = ACCUM;
          end
`else
          blue_next  = blue;
          state_next = DONE;
`endif
        end else if (state == WAIT_SOF && pix_valid && pix_sof) begin
          state_next = SCAN;
        end
      end
`ifdef CAM_PIXEL_PROBE_AVG4_EN
      ACCUM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (pix_valid) begin
          if (pix_sof) begin
            blue_next  = fill(acc, last, n_cnt);
            state_next = DONE;
          end else if (n_sum == 3'd4 || pix_eol) begin
            blue_next  = fill(acc_sum, blue, n_sum);
            state_next = DONE;
          end else begin
            acc_next  = acc_sum;
            n_next    = n_sum;
            last_next = blue;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      blue_reg <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      tx       <= '0;
      ty       <= '0;
`ifdef CAM_PIXEL_PROBE_AVG4_EN
      acc      <= '0;
      n_cnt    <= '0;
      last     <= '0;
`endif
    end else begin
      state    <= state_next;
      blue_reg <= blue_next;
      x_cnt    <= x_next;
      y_cnt    <= y_next;
      if (latch) begin
        tx <= target_x;
        ty <= target_y;
      end
`ifdef CAM_PIXEL_PROBE_AVG4_EN
      acc      <= acc_next;
      n_cnt    <= n_next;
      last     <= last_next;
`endif
    end
  end

  assign blue_out = blue_reg;
  assign done     = (state == DONE);
`ifdef CAM_PIXEL_PROBE_AVG4_EN
  assign busy     = (state == WAIT_SOF) || (state == SCAN) || (state == ACCUM);
`else
  assign busy     = (state == WAIT_SOF) || (state == SCAN);
`endif

endmodule

// File: tb/tb_cam_pixel_probe.sv
// Directed bench for cam_pixel_probe: 8x4 frames with blue = 16*y + x unless noted.
module tb_cam_pixel_probe;
  localparam int unsigned CW = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] target_x = '0;
  logic [CW-1:0] target_y = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_eol = 1'b0;
  logic [23:0]   pix_data = '0;
  logic [7:0]    blue_out;
  logic          done;
  logic          busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cam_pixel_probe #(.CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .target_x(target_x), .target_y(target_y),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_data(pix_data),
    .blue_out(blue_out), .done(done), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sof, input logic eol, input logic [7:0] b);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_eol   = eol;
    pix_data  = {8'h5A, 8'hC3, b};
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    pix_data  = 24'hFFFFFF;
  endtask

  // Invalid cycles carry misleading sideband and data that must be ignored.
  task automatic gap(input int n);
    pix_valid = 1'b0;
    pix_sof   = 1'b1;
    pix_eol   = 1'b1;
    pix_data  = 24'h0000EE;
    repeat (n) tick();
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic do_arm(input int x, input int y);
    target_x = CW'(x);
    target_y = CW'(y);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    target_x = '1;
    target_y = '1;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic frame(input int w, input int h, input int base);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        beat(x == 0 && y == 0, x == w - 1, 8'(base + 16 * y + x));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++; if (blue_out !== 8'h00) begin n_fail++; $display("FAIL reset_blue: got %h expected 00", blue_out); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_arm(3, 2);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_arm: got %b expected 0", done); end
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        beat(x == 0 && y == 0, x == 7, 8'(16 * y + x));
        if (y == 2 && x == 2) begin
          n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early: done=%b expected 0", done); end
        end
        if (y == 2 && x == 3) begin
          n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
          n_checks++; if (blue_out !== 8'h23) begin n_fail++; $display("FAIL basic_blue: got %h expected 23", blue_out); end
        end
      end
    frame(8, 4, 8'h40);
    n_checks++; if (blue_out !== 8'h23) begin n_fail++; $display("FAIL basic_hold_blue: got %h expected 23", blue_out); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_hold_done: got %b expected 1", done); end
  endtask

  task automatic test_edges();
    do_arm(0, 0);
    n_checks++; if (blue_out !== 8'h23) begin n_fail++; $display("FAIL edge_keep_blue: got %h expected 23", blue_out); end
    beat(1'b1, 1'b0, 8'h00);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL edge00_done: got %b expected 1", done); end
    n_checks++; if (blue_out !== 8'h00) begin n_fail++; $display("FAIL edge00_blue: got %h expected 00", blue_out); end
    do_arm(7, 3);
    frame(8, 4, 0);
    n_checks++; if (blue_out !== 8'h37) begin n_fail++; $display("FAIL edge73_blue: got %h expected 37", blue_out); end
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        if (y == 1 && x == 4) do_arm(2, 3);
        beat(x == 0 && y == 0, x == 7, 8'(8'h80 + 16 * y + x));
      end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midarm_same_frame: done=%b expected 0", done); end
    frame(8, 4, 0);
    n_checks++; if (blue_out !== 8'h32) begin n_fail++; $display("FAIL midarm_blue: got %h expected 32", blue_out); end
  endtask

  task automatic test_gapped();
    do_arm(5, 1);
    beat(1'b0, 1'b0, 8'h15);
    beat(1'b0, 1'b1, 8'h15);
    beat(1'b0, 1'b0, 8'h15);
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_sof: done=%b busy=%b expected 0/1", done, busy); end
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        beat(x == 0 && y == 0, x == 7, 8'(16 * y + x));
        if (y == 1 && x == 5) begin
          n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %b expected 1", done); end
          n_checks++; if (blue_out !== 8'h15) begin n_fail++; $display("FAIL gap_blue: got %h expected 15", blue_out); end
        end
        gap((x + y) % 3);
      end
  endtask

  task automatic test_out_of_range();
    do_arm(9, 0);
    for (int f = 0; f < 3; f++) begin
      frame(8, 4, 0);
      n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL oor_frame%0d: done=%b busy=%b expected 0/1", f, done, busy); end
    end
    do_abort();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL oor_abort: busy=%b done=%b expected 0/0", busy, done); end
    n_checks++; if (blue_out !== 8'h15) begin n_fail++; $display("FAIL oor_abort_blue: got %h expected 15", blue_out); end
  endtask

  task automatic test_races();
    target_x = CW'(1);
    target_y = CW'(1);
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL race_idle: busy=%b done=%b expected 0/0", busy, done); end
    do_arm(1, 1);
    do_arm(6, 2);
    frame(8, 4, 0);
    n_checks++; if (blue_out !== 8'h11 || done !== 1'b1) begin n_fail++; $display("FAIL rearm_ignored: blue=%h done=%b expected 11/1", blue_out, done); end
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL race_done: busy=%b done=%b expected 0/0", busy, done); end
    n_checks++; if (blue_out !== 8'h11) begin n_fail++; $display("FAIL race_done_blue: got %h expected 11", blue_out); end
  endtask

  task automatic test_reset_mid();
    do_arm(4, 3);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 8; x++)
        beat(x == 0 && y == 0, x == 7, 8'(16 * y + x));
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (blue_out !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid: blue=%h done=%b busy=%b expected 00/0/0", blue_out, done, busy); end
    tick();
    reset_n = 1'b1;
    tick();
    frame(8, 4, 0);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_avg4();
    logic [7:0] row [8];
    row = '{8'h01, 8'h01, 8'h10, 8'h20, 8'h30, 8'h41, 8'hF0, 8'hF0};
    do_arm(2, 0);
    for (int x = 0; x < 8; x++) begin
      beat(x == 0, x == 7, row[x]);
      if (x == 4) begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL avg_early: done=%b expected 0", done); end
      end
      if (x == 5) begin
        n_checks++; if (done !== 1'b1 || blue_out !== 8'h28) begin n_fail++; $display("FAIL avg_full: done=%b blue=%h expected 1/28", done, blue_out); end
      end
    end
    row = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'hA0, 8'hB0};
    do_arm(6, 0);
    for (int x = 0; x < 8; x++) begin
      beat(x == 0, x == 7, row[x]);
      if (x == 6) begin
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL avg_eol_early: done=%b busy=%b expected 0/1", done, busy); end
      end
    end
    n_checks++; if (done !== 1'b1 || blue_out !== 8'hAC) begin n_fail++; $display("FAIL avg_eol: done=%b blue=%h expected 1/ac", done, blue_out); end
  endtask

  initial begin
    test_reset();
`ifdef CAM_PIXEL_PROBE_AVG4_EN
    test_avg4();
`else
    test_basic();
    test_edges();
    test_gapped();
    test_out_of_range();
    test_races();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
